// File: rtl/bus_arbiter_rr_if.sv
// Bus-arbiter handshake bundle: per-source requests in, registered grant/encoding out.
// The master modport belongs to the requesting side; the slave modport belongs to the arbiter.
interface bus_arbiter_rr_if #(
    parameter int unsigned NUM_REQ = 24,
    parameter int unsigned CODE_W  = 5
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [CODE_W-1:0]  bus_code;
    logic               bus_valid;
    logic               timeout;

    modport master (
        output req,
        input  grant, bus_code, bus_valid, timeout
    );

    modport slave (
        input  req,
        output grant, bus_code, bus_valid, timeout
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin CPU-bus source arbiter: registered one-hot grant, one dead cycle between owners.
// Define BUS_ARB_TIMEOUT_EN to enforce MAX_HOLD with a one-cycle timeout pulse on forced release.
module bus_arbiter_rr #(
    parameter int unsigned NUM_REQ  = 24,
    parameter int unsigned CODE_W   = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    bus_arbiter_rr_if.slave  bus
);

    if ((1 << CODE_W) < NUM_REQ) begin : g_bad_code_w
        $error("CODE_W too narrow for NUM_REQ");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD outside 2..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CODE_W-1:0]  code_q,  code_d;
    logic [CODE_W-1:0]  ptr_q,   ptr_d;
    logic               valid_q, valid_d;

    logic               win_found;
    logic [CODE_W-1:0]  win_idx;
    logic               hold_hit;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign hold_hit = (hold_q >= 8'(MAX_HOLD - 1));
`else
    assign hold_hit = 1'b0;
`endif

    // Search upward from ptr+1, wrapping, so the last winner has lowest priority.
    always_comb begin
        int unsigned idx;
        logic [CODE_W-1:0] sel;
        idx       = 0;
        sel       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = CODE_W'(idx);
            if (!win_found && bus.req[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        code_d  = code_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE, TURN: begin
                if (win_found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    code_d  = win_idx;
                    valid_d = 1'b1;
                    ptr_d   = win_idx;
                    state_d = OWN;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!bus.req[code_q] || hold_hit) begin
                    grant_d = '0;
                    code_d  = '0;
                    valid_d = 1'b0;
                    state_d = TURN;
`ifdef BUS_ARB_TIMEOUT_EN
                    timeout_d = bus.req[code_q] && hold_hit;
`endif
                end
`ifdef BUS_ARB_TIMEOUT_EN
                if (hold_q < 8'(MAX_HOLD - 1)) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                code_d  = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= CODE_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant     = grant_q;
    assign bus.bus_code  = code_q;
    assign bus.bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: reset, rotation, wrap, async clear, hold-limit behaviour.
module tb_bus_arbiter_rr;

    logic clk;
    logic clear_n;
    int   vectors;
    int   miscompares;

    bus_arbiter_rr_if #(.NUM_REQ(24), .CODE_W(5)) bus ();

    bus_arbiter_rr #(
        .NUM_REQ (24),
        .CODE_W  (5),
        .MAX_HOLD(4)
    ) dut (
        .clk    (clk),
        .clear_n(clear_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [23:0] g, input logic [4:0] c,
                           input logic v, input logic t);
        chk({tag, ".grant"},     32'(bus.grant),     32'(g));
        chk({tag, ".bus_code"},  32'(bus.bus_code),  32'(c));
        chk({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'(v));
        chk({tag, ".timeout"},   32'(bus.timeout),   32'(t));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_n     = 1'b0;
        bus.req     = 24'hFFFFFF;

        tick();
        tick();
        chk_bus("reset", 24'h0, 5'd0, 1'b0, 1'b0);

        clear_n = 1'b1;
        tick();
        chk_bus("first_grant", 24'h000001, 5'd0, 1'b1, 1'b0);
        tick();
        chk_bus("first_hold", 24'h000001, 5'd0, 1'b1, 1'b0);

        // Async clear between edges, then restart with bits 0,2,5.
        #2;
        clear_n = 1'b0;
        #1;
        chk_bus("async_clear", 24'h0, 5'd0, 1'b0, 1'b0);
        bus.req = 24'h000025;
        #1;
        clear_n = 1'b1;

        tick();
        chk_bus("rot_own0", 24'h000001, 5'd0, 1'b1, 1'b0);
        tick();
        chk_bus("rot_own0_b", 24'h000001, 5'd0, 1'b1, 1'b0);
        bus.req = 24'h000024;
        tick();
        chk_bus("rot_turn0", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk_bus("rot_own2", 24'h000004, 5'd2, 1'b1, 1'b0);
        tick();
        chk_bus("rot_own2_b", 24'h000004, 5'd2, 1'b1, 1'b0);
        bus.req = 24'h000020;
        tick();
        chk_bus("rot_turn2", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk_bus("rot_own5", 24'h000020, 5'd5, 1'b1, 1'b0);
        tick();
        chk_bus("rot_own5_b", 24'h000020, 5'd5, 1'b1, 1'b0);
        bus.req = 24'h000000;
        tick();
        chk_bus("rot_turn5", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk_bus("rot_idle", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk_bus("idle_zero_req", 24'h0, 5'd0, 1'b0, 1'b0);

        // Move ptr to 23, then bit 0 must win over bit 23.
        bus.req = 24'h800000;
        tick();
        chk_bus("wrap_own23", 24'h800000, 5'd23, 1'b1, 1'b0);
        bus.req = 24'h000000;
        tick();
        chk_bus("wrap_turn", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();
        bus.req = 24'h800001;
        tick();
        chk_bus("wrap_own0", 24'h000001, 5'd0, 1'b1, 1'b0);
        bus.req = 24'h000000;
        tick();
        chk_bus("wrap_release", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        bus.req = 24'h000108;
        tick();
        chk_bus("to_own3_c0", 24'h000008, 5'd3, 1'b1, 1'b0);
        tick();
        chk_bus("to_own3_c1", 24'h000008, 5'd3, 1'b1, 1'b0);
        tick();
        chk_bus("to_own3_c2", 24'h000008, 5'd3, 1'b1, 1'b0);
        tick();
        chk_bus("to_own3_c3", 24'h000008, 5'd3, 1'b1, 1'b0);
        tick();
        chk_bus("to_pulse", 24'h0, 5'd0, 1'b0, 1'b1);
        tick();
        chk_bus("to_own8", 24'h000100, 5'd8, 1'b1, 1'b0);
        bus.req = 24'h000000;
        tick();
        chk_bus("to_own8_rel", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();

        // Lone requester held high regains the bus after the turnaround.
        bus.req = 24'h000008;
        tick();
        chk_bus("solo_own", 24'h000008, 5'd3, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_bus("solo_last", 24'h000008, 5'd3, 1'b1, 1'b0);
        tick();
        chk_bus("solo_pulse", 24'h0, 5'd0, 1'b0, 1'b1);
        tick();
        chk_bus("solo_regain", 24'h000008, 5'd3, 1'b1, 1'b0);
        bus.req = 24'h000000;
        tick();
        chk_bus("solo_rel", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();
`else
        bus.req = 24'h000008;
        tick();
        chk_bus("hold_own3", 24'h000008, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("hold_grant",   32'(bus.grant),   32'h000008);
            chk("hold_timeout", 32'(bus.timeout), 32'h0);
        end
        bus.req = 24'h000000;
        tick();
        chk_bus("hold_rel", 24'h0, 5'd0, 1'b0, 1'b0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
